// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter that sits directly downstream of synch_fifo on the same
// clock. It issues FIFO reads (registered read data, one cycle of latency) and
// holds the returned words in a 2-entry skid buffer. The buffer head is
// presented as a valid/ready stream. out_last marks every BURST_LEN-th beat.
//
// Optional feature (macro FIFO_RD_STREAM_CNT_EN):
//   Adds the output beat_total[15:0]. It is a free-running, wrapping count of
//   the stream pops since reset.
//
// Ports
//   fifo_clk         in   clock, rising edge
//   rst_n            in   synchronous active-low reset
//   fifo_data_avail  in   occupied entries in the upstream FIFO
//   fifo_rden        out  read strobe to the FIFO (combinational)
//   fifo_rddata      in   FIFO read data, valid the cycle after fifo_rden
//   out_valid        out  stream word valid
//   out_ready        in   downstream accepts the word
//   out_data         out  stream word (registered buffer head)
//   out_last         out  final beat of the current burst
//   beat_total       out  pop count (only with FIFO_RD_STREAM_CNT_EN)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int FIFO_PTR   = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int BCNT_W     = 4
) (
    input  logic                  fifo_clk,
    input  logic                  rst_n,
    input  logic [FIFO_PTR:0]     fifo_data_avail,
    output logic                  fifo_rden,
    input  logic [FIFO_WIDTH-1:0] fifo_rddata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           beat_total
`endif
);

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);

    logic [1:0]            buf_cnt_q,  buf_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [FIFO_WIDTH-1:0] buf0_q,     buf0_d;     // head of the skid buffer
    logic [FIFO_WIDTH-1:0] buf1_q,     buf1_d;     // second entry
    logic                  pop;
    logic                  last_beat;
    logic [2:0]            occ;

    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign pop       = out_valid && out_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign out_last  = out_valid && last_beat;

    // Occupancy after this cycle's pop, with reads already on the way counted
    // in. A pop can only happen when buf_cnt >= 1, so there is no underflow.
    assign occ = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Gated by rst_n so that no read leaves the FIFO while reset is held,
    // even on the very first edge before the state has been cleared.
    assign fifo_rden = rst_n && (fifo_data_avail != '0) && (occ < 3'd2);

    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = fifo_rden;

        // A capture lands at the tail. When it coincides with a pop, the buffer
        // first shifts and then appends, so the word order is kept.
        case ({inflight_q, pop})
            2'b01: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d = fifo_rddata;
                end else begin
                    buf1_d = fifo_rddata;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = fifo_rddata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rddata;
                end
            end
            default: ;
        endcase

        if (pop) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (!rst_n) begin
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] beat_total_q, beat_total_d;

    assign beat_total = beat_total_q;

    always_comb begin
        beat_total_d = beat_total_q;
        if (pop) begin
            beat_total_d = beat_total_q + 16'd1;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (!rst_n) begin
            beat_total_q <= 16'd0;
        end else begin
            beat_total_q <= beat_total_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. A behavioural FIFO with registered read
// data feeds the DUT. Every word loaded into the FIFO is also pushed to a
// scoreboard. Each stream pop is compared against the scoreboard head and
// against an independent beat-position model for out_last.
// Define FIFO_RD_STREAM_CNT_EN to exercise the beat_total counter.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int BL = 4;

    logic       fifo_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic [4:0] fifo_data_avail;
    logic       fifo_rden;
    logic [7:0] fifo_rddata = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] beat_total;
`endif

    always #5 fifo_clk = ~fifo_clk;

    fifo_rd_stream #(
        .FIFO_PTR  (4),
        .FIFO_WIDTH(8),
        .BURST_LEN (BL),
        .BCNT_W    (4)
    ) dut (
        .fifo_clk       (fifo_clk),
        .rst_n          (rst_n),
        .fifo_data_avail(fifo_data_avail),
        .fifo_rden      (fifo_rden),
        .fifo_rddata    (fifo_rddata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .beat_total     (beat_total)
`endif
    );

    // Behavioural upstream FIFO: one cycle of registered read latency.
    logic [7:0] mem [64];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    bit         free_mode = 1'b0;

    always_comb fifo_data_avail = free_mode ? 5'd16 : 5'(wr_ptr - rd_ptr);

    always @(posedge fifo_clk) begin
        if (fifo_rden) begin
            fifo_rddata <= free_mode ? 8'(rd_ptr) : mem[rd_ptr % 64];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    // Scoreboard and counters
    logic [7:0] sb [$];
    int errors = 0, checks = 0;
    int exp_beat = 0;
    int pop_total = 0, rden_cnt = 0, last_cnt = 0, cyc = 0;
    int first_pop = -1, last_pop = -1;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        sb.push_back(d);
        wr_ptr++;
    endtask

    task automatic adv();
        @(posedge fifo_clk);
        #1;
    endtask

    // Sample at the falling edge: check stability, the pop data and out_last.
    task automatic sample();
        @(negedge fifo_clk);
        cyc++;
        if (fifo_rden) rden_cnt++;
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid) chk("last", 32'(out_last), 32'(exp_beat == BL - 1));
        else           chk("last_idle", 32'(out_last), 32'd0);
        if (out_valid && out_ready) begin
            pop_total++;
            if (out_last) last_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (!free_mode) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("data", 32'(out_data), 32'(sb.pop_front()));
            end
            exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin
            adv();
            sample();
            chk("rst_rden", 32'(fifo_rden), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
        end
        wr_ptr = rd_ptr;
        sb.delete();
        exp_beat  = 0;
        prev_hold = 1'b0;
        adv();
        rst_n     = 1'b1;
        pop_total = 0;
        rden_cnt  = 0;
        last_cnt  = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (sb.size() != 0 || out_valid); i++) begin
            sample();
            adv();
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with data waiting in the FIFO.
        #1;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        do_reset();
        sample();
        chk("post_rst_data", 32'(out_data), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        adv();

        // Single word: read at t, capture at t+1, valid at t+2 only.
        out_ready = 1'b1;
        push(8'hA5);
        sample();
        chk("sw_rden_t", 32'(fifo_rden), 32'd1);
        chk("sw_valid_t", 32'(out_valid), 32'd0);
        adv();
        sample();
        chk("sw_rden_t1", 32'(fifo_rden), 32'd0);
        chk("sw_valid_t1", 32'(out_valid), 32'd0);
        adv();
        sample();
        chk("sw_valid_t2", 32'(out_valid), 32'd1);
        chk("sw_data_t2", 32'(out_data), 32'hA5);
        adv();
        sample();
        chk("sw_valid_t3", 32'(out_valid), 32'd0);
        adv();

        // Streaming: 8 beats back to back, out_last on 0x04 and 0x08.
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        drain(40);
        chk("st_pops", 32'(pop_total), 32'd8);
        chk("st_lasts", 32'(last_cnt), 32'd2);
        chk("st_span", 32'(last_pop - first_pop), 32'd7);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("st_beat_total", 32'(beat_total), 32'd8);
`endif

        // Back-pressure: at most two reads during a 10-cycle stall.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (10) begin
            sample();
            if (out_valid) chk("bp_data", 32'(out_data), 32'h01);
            adv();
        end
        chk("bp_rden_cnt", 32'(rden_cnt), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain(40);
        chk("bp_pops", 32'(pop_total), 32'd8);

        // FIFO runs empty mid-burst; the burst then resumes with new words.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
        drain(40);
        chk("mb_pops", 32'(pop_total), 32'd6);
        chk("mb_lasts", 32'(last_cnt), 32'd1);
        chk("mb_beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
        repeat (3) begin
            sample();
            adv();
        end
        last_cnt = 0;
        push(8'h50);
        push(8'h51);
        drain(40);
        chk("mb_resume_last", 32'(last_cnt), 32'd1);
        chk("mb_beat_cnt_wrap", 32'(dut.beat_cnt_q), 32'd0);

        // Random back-pressure.
        do_reset();
        for (int i = 0; i < 12; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) begin
            out_ready = 1'($urandom_range(0, 1));
            sample();
            adv();
        end
        out_ready = 1'b1;
        chk("rnd_drained", 32'(sb.size()), 32'd0);
        chk("rnd_pops", 32'(pop_total), 32'd12);

`ifdef FIFO_RD_STREAM_CNT_EN
        // 70000 pops wrap the 16-bit total to 4464.
        do_reset();
        free_mode = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 72000 && pop_total < 70000; i++) begin
            sample();
            adv();
        end
        chk("cnt_pops_reached", 32'(pop_total >= 70000), 32'd1);
        sample();
        chk("cnt_beat_total", 32'(beat_total), 32'd4464);
        out_ready = 1'b0;
        adv();
        free_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
